// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C configuration frame loader.
// A frame is SWITCH_TO, {ADDR[6:0], DEST}, then four payload bytes MSB first.
package i2c_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    PAY     = 3'd2,
    WRITE   = 3'd3,
    DISCARD = 3'd4
  } state_t;

  localparam int FRAME_BYTES   = 6;
  localparam int PAY_BYTES     = 4;
  // Bytes that follow a rejected bank select and must be swallowed.
  localparam int DISCARD_BYTES = FRAME_BYTES - 1;

  localparam logic DEST_MASK    = 1'b0;
  localparam logic DEST_PATTERN = 1'b1;

endpackage

// File: rtl/i2c_tgl_sync.sv
// Brings the receiver's per-byte READ toggle into the CLK domain and turns
// each toggle edge (either direction) into a one-cycle byte strobe.
module i2c_tgl_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic tgl,
  output logic stb
);

  logic sync1;
  logic sync2;
  logic sync3;

  // Two-flop synchroniser followed by one delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= tgl;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign stb = sync2 ^ sync3;

endmodule

// File: rtl/i2c_cfg_loader.sv
// Assembles six-byte configuration frames from the I2C receiver byte stream
// and issues one 32-bit write per frame into the mask/pattern banks.
// Optional build macro CFG_BANK_CHECK_EN: range-checks the bank select and
// discards frames that address a non-existent bank (raising ERR_BANK).
// dbg_state exposes the frame FSM state for observation.
module i2c_cfg_loader
  import i2c_cfg_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_W     = 2,
  parameter int TMO_CYCLES = 100000,
  parameter int TMO_W      = 17
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [7:0]        BYTE_IN,
  input  logic              READ_TGL,
  output logic              WR_VALID,
  input  logic              WR_READY,
  output logic [BANK_W-1:0] WR_BANK,
  output logic              WR_DEST,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [31:0]       WR_DATA,
  input  logic              CLR_ERR,
  output logic              ERR_OVR,
  output logic              ERR_TMO,
  output logic              ERR_BANK,
  output logic [7:0]        FRAME_CNT,
  output state_t            dbg_state
);

  if (BANK_W != $clog2(NUM_BANKS)) begin : g_bad_bank_w
    $error("BANK_W must equal clog2(NUM_BANKS)");
  end

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
  localparam logic [2:0]       PAY_LAST = 3'(PAY_BYTES - 1);
  localparam logic [2:0]       DIS_LAST = 3'(DISCARD_BYTES - 1);

  state_t           state_q;
  state_t           state_d;
  logic             byte_stb;
  logic [2:0]       idx_q;
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_run;
  logic             tmo_expired;
  logic             set_ovr;
  logic             set_tmo;
  logic             wr_done;

  i2c_tgl_sync u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .tgl   (READ_TGL),
    .stb   (byte_stb)
  );

  // Write handshake: WR_VALID is high exactly while in WRITE; the request
  // and its fields hold steady until a cycle with WR_READY=1, which is the
  // transfer cycle. WR_VALID falls the cycle after, or at a reset edge.
  assign WR_VALID  = (state_q == WRITE);
  assign dbg_state = state_q;

  assign tmo_run     = (state_q == HDR) || (state_q == PAY) || (state_q == DISCARD);
  // A byte strobe always beats an expiring timeout.
  assign tmo_expired = tmo_run && !byte_stb && (tmo_q == TMO_LAST);

`ifdef CFG_BANK_CHECK_EN
  logic set_bank;
  logic err_bank_q;
  assign ERR_BANK = err_bank_q;
`else
  assign ERR_BANK = 1'b0;
`endif

  // Frame FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and error/completion events.
  always_comb begin
    state_d = state_q;
    set_ovr = 1'b0;
    set_tmo = 1'b0;
    wr_done = 1'b0;
`ifdef CFG_BANK_CHECK_EN
    set_bank = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (byte_stb) begin
          state_d = HDR;
`ifdef CFG_BANK_CHECK_EN
          if (int'(BYTE_IN) >= NUM_BANKS) begin
            state_d  = DISCARD;
            set_bank = 1'b1;
          end
`endif
        end
      end
      HDR: begin
        if (byte_stb) begin
          state_d = PAY;
        end else if (tmo_expired) begin
          state_d = IDLE;
          set_tmo = 1'b1;
        end
      end
      PAY: begin
        if (byte_stb) begin
          if (idx_q == PAY_LAST) state_d = WRITE;
        end else if (tmo_expired) begin
          state_d = IDLE;
          set_tmo = 1'b1;
        end
      end
      WRITE: begin
        // Bytes arriving during a pending write are dropped, even if the
        // write completes in the same cycle.
        if (byte_stb) set_ovr = 1'b1;
        if (WR_READY) begin
          state_d = IDLE;
          wr_done = 1'b1;
        end
      end
      DISCARD: begin
        if (byte_stb) begin
          if (idx_q == DIS_LAST) state_d = IDLE;
        end else if (tmo_expired) begin
          state_d = IDLE;
          set_tmo = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte capture, timeout counter, frame counter and sticky error flags.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      WR_BANK   <= '0;
      WR_DEST   <= 1'b0;
      WR_ADDR   <= '0;
      WR_DATA   <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
      FRAME_CNT <= '0;
      ERR_OVR   <= 1'b0;
      ERR_TMO   <= 1'b0;
    end else begin
      if (byte_stb || !tmo_run || set_tmo) tmo_q <= '0;
      else                                 tmo_q <= tmo_q + 1'b1;

      if (byte_stb) begin
        case (state_q)
          IDLE: begin
            WR_BANK <= BYTE_IN[BANK_W-1:0];
            idx_q   <= '0;
          end
          HDR: begin
            WR_ADDR <= ADDR_W'(BYTE_IN[7:1]);
            WR_DEST <= BYTE_IN[0] ? DEST_PATTERN : DEST_MASK;
            idx_q   <= '0;
          end
          PAY: begin
            WR_DATA <= {WR_DATA[23:0], BYTE_IN};
            idx_q   <= idx_q + 1'b1;
          end
          DISCARD: idx_q <= idx_q + 1'b1;
          default: ;
        endcase
      end

      if (wr_done) FRAME_CNT <= FRAME_CNT + 1'b1;

      if (set_ovr)      ERR_OVR <= 1'b1;
      else if (CLR_ERR) ERR_OVR <= 1'b0;
      if (set_tmo)      ERR_TMO <= 1'b1;
      else if (CLR_ERR) ERR_TMO <= 1'b0;
    end
  end

`ifdef CFG_BANK_CHECK_EN
  // Sticky bank range error.
  always_ff @(posedge CLK) begin
    if (!RST_N)        err_bank_q <= 1'b0;
    else if (set_bank) err_bank_q <= 1'b1;
    else if (CLR_ERR)  err_bank_q <= 1'b0;
  end
`endif

endmodule
